window_feeder: RTL and testbench
================================

WINDOW_FEEDER -- requirements
Module: window_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 16, image width in pixels (>=3).
REQ-003 SHALL have parameter IMG_H, default 16, image height in lines (>=3).
REQ-004 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port PSI  input  1  input pixel valid, raster order.
REQ-007 SHALL have port PI  input  DATA_WIDTH  input pixel.
REQ-008 SHALL have port RDY  output  1  feeder accepts a pixel this cycle.
REQ-009 SHALL have port MED_DONE  input  1  median stage result strobe (its DSO).
REQ-010 SHALL have port DO  output  DATA_WIDTH  window pixel to median stage DI.
REQ-011 SHALL have port DSO  output  1  window pixel valid, drives median stage DSI.

Function
REQ-012 SHALL accept a pixel only when PSI and RDY are both 1; PSI with RDY=0 ignored, no state change.
REQ-013 SHALL track col 0..IMG_W-1 and row 0..IMG_H-1; col wraps to 0 with row+1; row wraps to 0 after (IMG_H-1, IMG_W-1).
REQ-014 SHALL store the two previous lines in line buffers; on acceptance at (row,col), shift a 3x3 window left and load new right column {line[row-2][col], line[row-1][col], PI}.
REQ-015 SHALL use FSM states IDLE, EMIT, WAIT; RDY=1 only in IDLE.
REQ-016 IDLE->EMIT on accepted pixel with row>=2 and col>=2; otherwise remain IDLE.
REQ-017 EMIT SHALL last exactly 9 cycles with DSO=1, DO = window[k/3][k%3], k=0..8, row-major, oldest row and leftmost column first.
REQ-018 Latency: accept at cycle t -> DSO=1 cycles t+1..t+9, WAIT from t+10.
REQ-019 WAIT->IDLE on MED_DONE=1; RDY=1 the following cycle.
REQ-020 MED_DONE in IDLE or EMIT SHALL be ignored.
REQ-021 Window columns from col 0..1 of a line SHALL never be emitted (no border padding); each line yields IMG_W-2 windows.
REQ-022 DO SHALL be 0 whenever DSO=0.

Reset
REQ-023 nRST=0 SHALL asynchronously force state IDLE, row=0, col=0, DSO=0, DO=0, RDY=0, emit counter 0.
REQ-024 RDY SHALL rise the first cycle after nRST deasserts.
REQ-025 Reset mid-EMIT SHALL drop DSO immediately; no partial window resumes.
REQ-026 Line buffer and window contents SHALL not be reset.

Configuration
REQ-027 Macro WINDOW_FEEDER_TIMEOUT_EN SHALL, when defined, add output TMO (1 bit, reset 0) and a 6-bit WAIT counter.
REQ-028 With WINDOW_FEEDER_TIMEOUT_EN: 32 WAIT cycles without MED_DONE -> return to IDLE, TMO pulses 1 cycle.
REQ-029 Without WINDOW_FEEDER_TIMEOUT_EN: no TMO port, WAIT is unbounded.

Structure
REQ-030 Package window_pkg SHALL hold the FSM state enum and constant WIN_SIZE=9.
REQ-031 Sub-module line_buf (IMG_W deep, DATA_WIDTH wide, read-before-write at col) SHALL be instantiated twice.

Verification
REQ-032 Reset: nRST=0 mid-EMIT -> DSO=0, DO=0 same cycle; RDY=1 one cycle after release.
REQ-033 IMG_W=4, IMG_H=4, pixels 1..16, MED_DONE 3 cycles after each burst -> bursts {1,2,3,5,6,7,9,10,11}, {2,3,4,6,7,8,10,11,12}, {5,6,7,9,10,11,13,14,15}, {6,7,8,10,11,12,14,15,16}.
REQ-034 PSI held 1 during EMIT/WAIT -> extra pixels not accepted, col/row unchanged.
REQ-035 Frame wrap: after pixel 16, next frame pixels 17..24 -> no burst until row 2 col 2 of new frame.
REQ-036 MED_DONE pulsed during EMIT -> ignored, WAIT still entered at t+10.
REQ-037 WINDOW_FEEDER_TIMEOUT_EN defined, MED_DONE never asserted -> TMO=1 at WAIT cycle 32, RDY=1 next cycle.

Source files
------------

// File: rtl/window_pkg.sv
// Shared types and constants for the 3x3 window feeder.
package window_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int WIN_DIM   = 3;
    localparam int WIN_SIZE  = 9;
    localparam int CNT_W     = 4;
    localparam int TMO_W     = 6;
    localparam int TMO_LIMIT = 32;

endpackage

// File: rtl/line_buf.sv
// One image line of storage; combinational read of the old value, write on the clock edge.
module line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_feeder.sv
// Builds 3x3 windows from a raster pixel stream and serialises each one to the median stage.
// Optional macro WINDOW_FEEDER_TIMEOUT_EN adds the TMO output and a bounded WAIT.
module window_feeder
    import window_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  PSI,
    input  logic [DATA_WIDTH-1:0] PI,
    output logic                  RDY,
    input  logic                  MED_DONE,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  DSO
`ifdef WINDOW_FEEDER_TIMEOUT_EN
    ,
    output logic                  TMO
`endif
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(2);

    state_t               state;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic [DATA_WIDTH-1:0] line1_q;
    logic [DATA_WIDTH-1:0] line2_q;
    logic [DATA_WIDTH-1:0] win     [0:WIN_SIZE-1];
    logic [DATA_WIDTH-1:0] win_nxt [0:WIN_SIZE-1];
`ifdef WINDOW_FEEDER_TIMEOUT_EN
    logic [TMO_W-1:0]     wcnt;
`endif

    assign accept = PSI & RDY;

    // line1 holds row-1; its old value cascades into line2, which holds row-2
    line_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (IMG_W),
        .ADDR_W    (COL_W)
    ) u_line1 (
        .clk    (CLK),
        .wr_en  (accept),
        .addr   (col),
        .wr_data(PI),
        .rd_data(line1_q)
    );

    line_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (IMG_W),
        .ADDR_W    (COL_W)
    ) u_line2 (
        .clk    (CLK),
        .wr_en  (accept),
        .addr   (col),
        .wr_data(line1_q),
        .rd_data(line2_q)
    );

    // window is row-major, index 0 = oldest row, leftmost column
    always_comb begin
        for (int r = 0; r < WIN_DIM; r++) begin
            win_nxt[r*WIN_DIM]     = win[r*WIN_DIM + 1];
            win_nxt[r*WIN_DIM + 1] = win[r*WIN_DIM + 2];
            win_nxt[r*WIN_DIM + 2] = win[r*WIN_DIM + 2];
        end
        win_nxt[WIN_DIM-1]   = line2_q;
        win_nxt[2*WIN_DIM-1] = line1_q;
        win_nxt[WIN_SIZE-1]  = PI;
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int i = 0; i < WIN_SIZE; i++) begin
                win[i] <= win_nxt[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
            cnt   <= '0;
            RDY   <= 1'b0;
            DSO   <= 1'b0;
            DO    <= '0;
`ifdef WINDOW_FEEDER_TIMEOUT_EN
            TMO   <= 1'b0;
            wcnt  <= '0;
`endif
        end else begin
`ifdef WINDOW_FEEDER_TIMEOUT_EN
            TMO <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    RDY <= 1'b1;
                    DSO <= 1'b0;
                    DO  <= '0;
                    if (accept) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        // first element goes out on the accept edge, so use the shifted window
                        if (row >= ROW_MIN && col >= COL_MIN) begin
                            state <= EMIT;
                            RDY   <= 1'b0;
                            DSO   <= 1'b1;
                            DO    <= win_nxt[0];
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (cnt == CNT_W'(WIN_SIZE)) begin
                        state <= WAIT;
                        DSO   <= 1'b0;
                        DO    <= '0;
                        cnt   <= '0;
`ifdef WINDOW_FEEDER_TIMEOUT_EN
                        wcnt  <= '0;
`endif
                    end else begin
                        DO  <= win[cnt];
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (MED_DONE) begin
                        state <= IDLE;
                        RDY   <= 1'b1;
                    end
`ifdef WINDOW_FEEDER_TIMEOUT_EN
                    else if (wcnt == TMO_W'(TMO_LIMIT - 1)) begin
                        state <= IDLE;
                        RDY   <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                        TMO  <= (wcnt == TMO_W'(TMO_LIMIT - 2));
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    RDY   <= 1'b0;
                    DSO   <= 1'b0;
                    DO    <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
// Randomised bench for window_feeder against a whole-frame reference image.
module tb_window_feeder;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          CLK      = 1'b0;
    logic          nRST     = 1'b0;
    logic          PSI      = 1'b0;
    logic          MED_DONE = 1'b0;
    logic [DW-1:0] PI       = '0;
    logic          RDY;
    logic          DSO;
    logic [DW-1:0] DO;
`ifdef WINDOW_FEEDER_TIMEOUT_EN
    logic          TMO;
`endif

    always #5 CLK = ~CLK;

    window_feeder #(
        .DATA_WIDTH(DW),
        .IMG_W     (W),
        .IMG_H     (H)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .PSI     (PSI),
        .PI      (PI),
        .RDY     (RDY),
        .MED_DONE(MED_DONE),
        .DO      (DO),
        .DSO     (DSO)
`ifdef WINDOW_FEEDER_TIMEOUT_EN
        ,
        .TMO     (TMO)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference: current frame image and raster position of the next pixel
    int            mr = 0;
    int            mc = 0;
    logic [DW-1:0] img [0:H-1][0:W-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_pixel(input logic [DW-1:0] v, input bit hold, input int d,
                              input bit med_in_emit, input int abort_k, input bit no_med);
        int            n;
        bit            burst;
        logic [DW-1:0] exp_w [0:8];
        n = 0;
        while (RDY !== 1'b1 && n < 64) begin
            @(negedge CLK);
            n++;
        end
        chk("rdy_before_pixel", 32'(RDY), 32'd1);
        burst = (mr >= 2 && mc >= 2);
        img[mr][mc] = v;
        if (burst) begin
            for (int k = 0; k < 9; k++) begin
                exp_w[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
            end
        end
        PSI = 1'b1;
        PI  = v;
        @(negedge CLK);
        PSI = burst && hold;
        PI  = DW'($urandom);
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr + 1) % H;
        end
        if (!burst) begin
            chk("idle_rdy", 32'(RDY), 32'd1);
            chk("idle_dso", 32'(DSO), 32'd0);
            return;
        end
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge CLK);
            chk("emit_dso", 32'(DSO), 32'd1);
            chk("emit_do", 32'(DO), 32'(exp_w[k]));
            if (k == abort_k) begin
                #2 nRST = 1'b0;
                #1;
                chk("rst_dso", 32'(DSO), 32'd0);
                chk("rst_do", 32'(DO), 32'd0);
                chk("rst_rdy", 32'(RDY), 32'd0);
                PSI      = 1'b0;
                MED_DONE = 1'b0;
                @(negedge CLK);
                nRST = 1'b1;
                @(negedge CLK);
                chk("rdy_after_rst", 32'(RDY), 32'd1);
                mr = 0;
                mc = 0;
                return;
            end
            if (med_in_emit && k == 4) MED_DONE = 1'b1;
            if (k == 5) MED_DONE = 1'b0;
        end
        @(negedge CLK);
        chk("wait_dso", 32'(DSO), 32'd0);
        chk("wait_do", 32'(DO), 32'd0);
        chk("wait_rdy", 32'(RDY), 32'd0);
`ifdef WINDOW_FEEDER_TIMEOUT_EN
        if (no_med) begin
            chk("tmo_early", 32'(TMO), 32'd0);
            repeat (31) @(negedge CLK);
            chk("tmo_pulse", 32'(TMO), 32'd1);
            chk("tmo_rdy_low", 32'(RDY), 32'd0);
            PSI = 1'b0;
            @(negedge CLK);
            chk("tmo_rdy", 32'(RDY), 32'd1);
            chk("tmo_clear", 32'(TMO), 32'd0);
            return;
        end
`else
        if (no_med) d = d + 1;
`endif
        repeat (d) @(negedge CLK);
        chk("rdy_still_low", 32'(RDY), 32'd0);
        MED_DONE = 1'b1;
        PSI      = 1'b0;
        @(negedge CLK);
        MED_DONE = 1'b0;
        chk("rdy_after_done", 32'(RDY), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        repeat (3) @(negedge CLK);
        chk("reset_rdy", 32'(RDY), 32'd0);
        chk("reset_dso", 32'(DSO), 32'd0);
        chk("reset_do", 32'(DO), 32'd0);
        nRST = 1'b1;
        @(negedge CLK);
        chk("rdy_after_release", 32'(RDY), 32'd1);

        // frame 1: pixels 1..16, MED_DONE three cycles after each burst
        for (int i = 1; i <= 16; i++) send_pixel(DW'(i), 1'b0, 3, 1'b0, -1, 1'b0);

        // frame 2: first two lines produce nothing, rest with PSI held and MED_DONE inside EMIT
        for (int i = 17; i <= 24; i++) send_pixel(DW'(i), 1'b0, 3, 1'b0, -1, 1'b0);
        for (int i = 0; i < 8; i++)
            send_pixel(DW'($urandom), 1'b1, $urandom_range(0, 4), 1'b1, -1, 1'b0);

        // frame 3: reset in the middle of the second window's burst
        p = 0;
        while (p < 16) begin
            send_pixel(DW'($urandom), 1'b0, $urandom_range(0, 3), 1'b0,
                       (p == 11) ? int'($urandom_range(1, 7)) : -1, 1'b0);
            p++;
        end

        // random frames
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < W * H; i++) begin
                send_pixel(DW'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                           1'($urandom_range(0, 1)), -1, ($urandom_range(0, 3) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
